// File: rtl/ahb_lite_bus_arbiter.sv
// Round-robin AHB-lite arbiter: one-hot grant, address/data-phase owner, bus lock.
// Build with AHB_ARB_HOLD_LIMIT_EN defined to add hold-time preemption after MAX_HOLD beats.
module ahb_lite_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MW-1:0]          HMASTER,
    output logic [MW-1:0]          HMASTER_DATA,
    output logic                   HMASTLOCK
);

    localparam logic [0:0] ST_PARK   = 1'b0;
    localparam logic [0:0] ST_OWN    = 1'b1;
    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [2:0] BU_SINGLE = 3'b000;

    logic [0:0]             state, state_nxt;
    logic [MW-1:0]          last_owner, owner_nxt, rr_win, cand;
    logic                   rr_found, sp, owner_lock, owner_req, grant_chg, preempt;
    logic [NUM_MASTERS-1:0] grant_nxt;

    // Grants may only move at an edge that ends a burst (idle or single transfer).
    assign sp         = HREADY && ((HTRANS == TR_IDLE) ||
                                   ((HTRANS == TR_NONSEQ) && (HBURST == BU_SINGLE)));
    assign owner_lock = HLOCK[HMASTER];
    assign owner_req  = HBUSREQ[HMASTER];
    assign HMASTLOCK  = owner_lock;

    // Scan starts just above the last served master, which is therefore checked last.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = MW'((int'(last_owner) + i) % NUM_MASTERS);
            if (!rr_found && HBUSREQ[cand]) begin
                rr_win   = cand;
                rr_found = 1'b1;
            end
        end
    end

`ifdef AHB_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_cnt;
    logic       others_req;

    assign others_req = |(HBUSREQ & ~HGRANT);
    assign preempt    = (hold_cnt == 8'(MAX_HOLD)) && others_req;

    // Counts issued beats (NONSEQ/SEQ) of the current owner, saturating at the limit.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_cnt <= 8'd0;
        end else if (grant_chg) begin
            hold_cnt <= 8'd0;
        end else if ((state == ST_OWN) && HREADY && HTRANS[1] &&
                     (hold_cnt != 8'(MAX_HOLD))) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = HMASTER;
        if (sp && !owner_lock) begin
            if (state == ST_PARK) begin
                if (|HBUSREQ) begin
                    state_nxt = ST_OWN;
                    owner_nxt = rr_win;
                end
            end else if (!owner_req) begin
                if (|HBUSREQ) begin
                    owner_nxt = rr_win;
                end else begin
                    state_nxt = ST_PARK;
                    owner_nxt = '0;
                end
            end else if (preempt) begin
                owner_nxt = rr_win;
            end
        end
    end

    assign grant_chg = (state_nxt != state) || (owner_nxt != HMASTER);
    assign grant_nxt = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_nxt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state        <= ST_PARK;
            last_owner   <= '0;
            HGRANT       <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
            HMASTER      <= '0;
            HMASTER_DATA <= '0;
        end else begin
            state   <= state_nxt;
            HGRANT  <= grant_nxt;
            HMASTER <= owner_nxt;
            if (grant_chg && (state_nxt == ST_OWN)) begin
                last_owner <= owner_nxt;
            end
            if (HREADY) begin
                HMASTER_DATA <= HMASTER;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// Directed bench for ahb_lite_bus_arbiter: per-cycle reference model plus literal checks.
module tb_ahb_lite_bus_arbiter;
    localparam int N  = 4;
    localparam int MH = 16;
`ifdef AHB_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

    logic         HCLK = 1'b0, HRESETn = 1'b1, HREADY = 1'b1;
    logic [N-1:0] HBUSREQ = '0, HLOCK = '0;
    logic [1:0]   HTRANS = IDLE;
    logic [2:0]   HBURST = SINGLE;
    logic [N-1:0] HGRANT;
    logic [1:0]   HMASTER, HMASTER_DATA;
    logic         HMASTLOCK;

    ahb_lite_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT),
        .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA), .HMASTLOCK(HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, who was served last, beats held, data-phase owner.
    int m_owner, m_last, m_cnt, m_data, m_win, m_nw;
    bit m_park, m_np, m_sp;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_owner = 0; m_last = 0; m_cnt = 0; m_data = 0; m_park = 1'b1;
        end else begin
            m_sp  = HREADY && (HTRANS == IDLE || (HTRANS == NONSEQ && HBURST == SINGLE));
            m_win = -1;
            for (int k = 1; k <= N; k++)
                if (m_win < 0 && HBUSREQ[(m_last + k) % N]) m_win = (m_last + k) % N;
            m_nw = m_owner; m_np = m_park;
            if (m_sp && !HLOCK[m_owner]) begin
                if (m_park) begin
                    if (m_win >= 0) begin m_nw = m_win; m_np = 1'b0; end
                end else if (!HBUSREQ[m_owner]) begin
                    if (m_win >= 0) m_nw = m_win;
                    else begin m_nw = 0; m_np = 1'b1; end
                end else if (HOLD_EN && m_cnt == MH && m_win >= 0 && m_win != m_owner) begin
                    m_nw = m_win;
                end
            end
            if (HREADY) m_data = m_owner;
            if (m_nw != m_owner || m_np != m_park) begin
                m_cnt = 0;
                if (!m_np) m_last = m_nw;
            end else if (!m_park && HREADY && (HTRANS == NONSEQ || HTRANS == SEQ) && m_cnt < MH) begin
                m_cnt++;
            end
            m_owner = m_nw; m_park = m_np;
        end
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            check("grant", int'(HGRANT), 1 << m_owner);
            check("hmaster", int'(HMASTER), m_owner);
            check("hmaster_data", int'(HMASTER_DATA), m_data);
            check("hmastlock", int'(HMASTLOCK), int'(HLOCK[m_owner]));
        end
    end

    task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] lck,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
        HBUSREQ = req; HLOCK = lck; HTRANS = tr; HBURST = bu; HREADY = rdy;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input logic [N-1:0] req);
        cyc(req, '0, IDLE, SINGLE, 1'b1);
    endtask

    int own;

    initial begin
        #1 HRESETn = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        check("rst_grant", int'(HGRANT), 1);
        check("rst_hmaster", int'(HMASTER), 0);

        // Park, then a lone request from master 2, then everyone drops.
        idle(4'b0100);
        check("park_to_m2", int'(HGRANT), 4'b0100);
        idle(4'b0000);
        check("back_to_park", int'(HGRANT), 4'b0001);
        check("park_data", int'(HMASTER_DATA), 2);

        // Mid-burst asynchronous reset.
        idle(4'b0010);
        check("m1_grant", int'(HGRANT), 4'b0010);
        cyc(4'b0010, '0, NONSEQ, INCR4, 1'b1);
        check("mid_data", int'(HMASTER_DATA), 1);
        #2 HRESETn = 1'b0;
        #1;
        check("arst_grant", int'(HGRANT), 1);
        check("arst_hmaster", int'(HMASTER), 0);
        check("arst_data", int'(HMASTER_DATA), 0);
        check("arst_lock", int'(HMASTLOCK), 0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Fairness: all request; each owner does one SINGLE then drops for a cycle.
        idle(4'b1111);
        check("fair_first", int'(HGRANT), 4'b0010);
        own = 1;
        for (int s = 0; s < 4; s++) begin
            cyc(4'b1111, '0, NONSEQ, SINGLE, 1'b1);
            check("fair_keep", int'(HGRANT), 1 << own);
            idle(4'b1111 & ~(4'b0001 << own));
            own = (own + 1) % N;
            check("fair_next", int'(HGRANT), 1 << own);
        end

        // Burst from master 2 with a wait state; master 1 waits for the burst end.
        idle(4'b0100);
        check("burst_own", int'(HGRANT), 4'b0100);
        cyc(4'b0010, '0, NONSEQ, INCR4, 1'b1);
        check("burst_b1", int'(HGRANT), 4'b0100);
        cyc(4'b0010, '0, SEQ, INCR4, 1'b1);
        check("burst_b2", int'(HGRANT), 4'b0100);
        cyc(4'b0010, '0, SEQ, INCR4, 1'b0);
        check("burst_wait", int'(HGRANT), 4'b0100);
        cyc(4'b0010, '0, SEQ, INCR4, 1'b1);
        check("burst_b3", int'(HGRANT), 4'b0100);
        cyc(4'b0010, '0, SEQ, INCR4, 1'b1);
        check("burst_b4", int'(HGRANT), 4'b0100);
        idle(4'b0010);
        check("burst_handover", int'(HGRANT), 4'b0010);
        check("burst_last_data", int'(HMASTER_DATA), 2);
        idle(4'b0010);
        check("burst_new_data", int'(HMASTER_DATA), 1);

        // Locked master 3 holds the bus for 40 beats despite master 0 requesting.
        cyc(4'b1001, 4'b1000, IDLE, SINGLE, 1'b1);
        check("lock_grant", int'(HGRANT), 4'b1000);
        for (int b = 0; b < 40; b++) begin
            cyc(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1);
            check("lock_hold", int'(HGRANT), 4'b1000);
            check("lock_flag", int'(HMASTLOCK), 1);
        end
        idle(4'b0001);
        check("unlock_m0", int'(HGRANT), 4'b0001);

        // Master 1 streams singles while master 3 waits.
        idle(4'b0010);
        check("stream_own", int'(HGRANT), 4'b0010);
        for (int b = 1; b <= 20; b++) begin
            cyc(4'b1010, '0, NONSEQ, SINGLE, 1'b1);
            check("preempt", int'(HMASTER), (HOLD_EN && b >= 17) ? 3 : 1);
        end

        idle(4'b0000);
        check("final_park", int'(HGRANT), 4'b0001);
        @(negedge HCLK);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
